// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and default timing for the push-button conditioner
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_e;

    // 20 ms debounce and 1 s long press at 12 MHz
    localparam int DEBOUNCE_CYCLES_DEF   = 240000;
    localparam int LONG_PRESS_CYCLES_DEF = 12000000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with asynchronous reset to a fixed level
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - debounced level plus press/release/long-press strobes for an active-low button
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_pressed,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_debounce: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
        $error("button_debounce: LONG_PRESS_CYCLES must be >= 1");
    end

    logic w_s;

    btn_state_e        r_state, w_state_nxt;
    logic [DB_W-1:0]   r_db_cnt, w_db_cnt_nxt;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic              r_long_done, w_long_done_nxt;
    logic              r_pressed, r_press_pulse, r_release_pulse, r_long_pulse;
    logic              w_pressed_nxt, w_press_nxt, w_release_nxt, w_long_nxt;
    logic              w_in_hold, w_long_hit;

    // Released level on reset so a button held through reset debounces as a fresh press
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_btn_n),
        .o_q   (w_s)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= RELEASED;
            r_db_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_db_cnt <= w_db_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_db_cnt_nxt = r_db_cnt;
        unique case (r_state)
            RELEASED: begin
                if (!w_s) begin
                    w_state_nxt  = PRESS_PEND;
                    w_db_cnt_nxt = '0;
                end
            end
            PRESS_PEND: begin
                if (w_s) begin
                    w_state_nxt  = RELEASED;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt  = HELD;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (w_s) begin
                    w_state_nxt  = RELEASE_PEND;
                    w_db_cnt_nxt = '0;
                end
            end
            RELEASE_PEND: begin
                if (!w_s) begin
                    w_state_nxt  = HELD;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt  = RELEASED;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt  = RELEASED;
                w_db_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_press_nxt     = (r_state == PRESS_PEND) && (w_state_nxt == HELD);
        w_release_nxt   = (r_state == RELEASE_PEND) && (w_state_nxt == RELEASED);
        w_pressed_nxt   = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_PEND);
        w_in_hold       = (r_state == HELD) || (r_state == RELEASE_PEND);
        w_long_hit      = w_in_hold && (r_hold_cnt == HOLD_LAST) && !r_long_done;
        // A release accepted on the same cycle swallows the long-press strobe
        w_long_nxt      = w_long_hit && !w_release_nxt;
        w_long_done_nxt = w_press_nxt ? 1'b0 : (r_long_done | w_long_hit);
        w_hold_cnt_nxt  = r_hold_cnt;
        if (w_press_nxt) begin
            w_hold_cnt_nxt = '0;
        end else if (w_in_hold && (r_hold_cnt != HOLD_LAST)) begin
            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_cnt      <= '0;
            r_long_done     <= 1'b0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
        end else begin
            r_hold_cnt      <= w_hold_cnt_nxt;
            r_long_done     <= w_long_done_nxt;
            r_pressed       <= w_pressed_nxt;
            r_press_pulse   <= w_press_nxt;
            r_release_pulse <= w_release_nxt;
            r_long_pulse    <= w_long_nxt;
        end
    end

    assign o_pressed       = r_pressed;
    assign o_press_pulse   = r_press_pulse;
    assign o_release_pulse = r_release_pulse;
    assign o_long_pulse    = r_long_pulse;

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed vector table and long-press sequences for button_debounce
module tb_button_debounce;

    logic clk;
    logic rst;
    logic btn_n;
    logic pressed, press_pulse, release_pulse, long_pulse;

    int n_vec;
    int n_bad;

    typedef struct {
        logic       rst;
        logic       btn_n;
        logic [3:0] exp;   // {pressed, press, release, long}
    } vec_t;

    vec_t vecs[$];

    button_debounce #(
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (16)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_btn_n         (btn_n),
        .o_pressed       (pressed),
        .o_press_pulse   (press_pulse),
        .o_release_pulse (release_pulse),
        .o_long_pulse    (long_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic b, input int n, input logic [3:0] e);
        vec_t v;
        v.rst   = r;
        v.btn_n = b;
        v.exp   = e;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic hold_seq(input int low_cycles, input int total_cycles,
                            output int press_at, output int long_at, output int release_at,
                            output int press_n, output int long_n, output int release_n,
                            output int overlap_n);
        press_at = -1; long_at = -1; release_at = -1;
        press_n = 0; long_n = 0; release_n = 0; overlap_n = 0;
        for (int k = 0; k < total_cycles; k++) begin
            btn_n = (k < low_cycles) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (press_pulse)   begin press_n++;   press_at = k;   end
            if (long_pulse)    begin long_n++;    long_at = k;    end
            if (release_pulse) begin release_n++; release_at = k; end
            if ((int'(press_pulse) + int'(release_pulse) + int'(long_pulse)) > 1) overlap_n++;
        end
    endtask

    initial begin
        int pa, la, ra, pn, ln, rn, ov;
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        btn_n = 1'b0;

        // Button held through reset, then debounced as a new press, then released
        add(1'b1, 1'b0, 3, 4'b0000);
        add(1'b0, 1'b0, 6, 4'b0000);
        add(1'b0, 1'b0, 1, 4'b1100);
        add(1'b0, 1'b0, 2, 4'b1000);
        add(1'b0, 1'b1, 6, 4'b1000);
        add(1'b0, 1'b1, 1, 4'b0010);
        add(1'b0, 1'b1, 2, 4'b0000);
        // Clean press held 10 cycles, strobe 7 cycles after the edge
        add(1'b0, 1'b0, 6, 4'b0000);
        add(1'b0, 1'b0, 1, 4'b1100);
        add(1'b0, 1'b0, 3, 4'b1000);
        add(1'b0, 1'b1, 6, 4'b1000);
        add(1'b0, 1'b1, 1, 4'b0010);
        add(1'b0, 1'b1, 2, 4'b0000);
        // Press bounce: low 3, high 1, low 3, high
        add(1'b0, 1'b0, 3, 4'b0000);
        add(1'b0, 1'b1, 1, 4'b0000);
        add(1'b0, 1'b0, 3, 4'b0000);
        add(1'b0, 1'b1, 6, 4'b0000);
        // Release bounce while held: high 2, low 2, then a real release
        add(1'b0, 1'b0, 6, 4'b0000);
        add(1'b0, 1'b0, 1, 4'b1100);
        add(1'b0, 1'b0, 3, 4'b1000);
        add(1'b0, 1'b1, 2, 4'b1000);
        add(1'b0, 1'b0, 2, 4'b1000);
        add(1'b0, 1'b1, 6, 4'b1000);
        add(1'b0, 1'b1, 1, 4'b0010);
        add(1'b0, 1'b1, 2, 4'b0000);
        // Reset mid-debounce restarts the full debounce
        add(1'b0, 1'b0, 4, 4'b0000);
        add(1'b1, 1'b0, 1, 4'b0000);
        add(1'b0, 1'b0, 6, 4'b0000);
        add(1'b0, 1'b0, 1, 4'b1100);
        add(1'b0, 1'b0, 2, 4'b1000);
        add(1'b0, 1'b1, 6, 4'b1000);
        add(1'b0, 1'b1, 1, 4'b0010);
        add(1'b0, 1'b1, 3, 4'b0000);

        #2;
        n_vec++;
        if ({pressed, press_pulse, release_pulse, long_pulse} != 4'b0000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b, expected 0000",
                     {pressed, press_pulse, release_pulse, long_pulse});
        end

        foreach (vecs[i]) begin
            rst   = vecs[i].rst;
            btn_n = vecs[i].btn_n;
            @(posedge clk);
            #1;
            n_vec++;
            if ({pressed, press_pulse, release_pulse, long_pulse} != vecs[i].exp) begin
                n_bad++;
                $display("FAIL table[%0d]: got %b, expected %b", i,
                         {pressed, press_pulse, release_pulse, long_pulse}, vecs[i].exp);
            end
        end

        // Long press: 40 cycles low then release
        hold_seq(40, 60, pa, la, ra, pn, ln, rn, ov);
        check_int("long.press_at", pa, 6);
        check_int("long.press_n", pn, 1);
        check_int("long.long_at", la, 22);
        check_int("long.long_n", ln, 1);
        check_int("long.release_at", ra, 46);
        check_int("long.release_n", rn, 1);
        check_int("long.overlap", ov, 0);
        check_int("long.pressed_end", int'(pressed), 0);

        // Release accepted on the same cycle the long press would fire
        hold_seq(16, 40, pa, la, ra, pn, ln, rn, ov);
        check_int("tie.press_at", pa, 6);
        check_int("tie.release_at", ra, 22);
        check_int("tie.release_n", rn, 1);
        check_int("tie.long_n", ln, 0);
        check_int("tie.overlap", ov, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
